// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for the multi-cycle datapath. Each instruction goes through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The unit drives the datapath mux
// selects, the ALU operation and the memory request lines.
//
// Memory handshake: a request (imem_req / dmem_req) stays high for as long as
// the FSM waits in FETCH / MEM. The matching ack completes the access in the
// same cycle it is seen high. An ack that arrives outside its wait state is
// ignored. If no ack arrives within TIMEOUT cycles, bus_err pulses for one
// cycle and the instruction is abandoned back to FETCH.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   opcode       instruction[31:26], valid together with imem_ack
//   imem_ack     instruction fetch complete
//   dmem_ack     data access complete
//   imem_req     fetch request
//   dmem_req     data access request, dmem_we = 1 for store
//   ir_write     latch instruction register
//   pc_write     unconditional PC update
//   branch       conditional PC update (gated with ALU zero downstream)
//   jump         select jump target
//   reg_dst      0 = rd, 1 = rt
//   alu_src      0 = register, 1 = sign-extended immediate
//   alu_op       ALU operation
//   mem_to_reg   write-back from memory data
//   reg_write    register-file write enable
//   illegal      1-cycle pulse on unsupported opcode
//   bus_err      1-cycle pulse on ack timeout
//   state        debug view: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int                 OPW         = 6,
  parameter int                 ALUOPW      = 6,
  parameter logic [ALUOPW-1:0]  RTYPE_ALUOP = 6'h3F,
  parameter logic [ALUOPW-1:0]  ADD_ALUOP   = 6'h06,
  parameter logic [ALUOPW-1:0]  SUB_ALUOP   = 6'h08,
  parameter int                 TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              ir_write,
  output logic              pc_write,
  output logic              branch,
  output logic              jump,
  output logic              reg_dst,
  output logic              alu_src,
  output logic [ALUOPW-1:0] alu_op,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_BEQ, C_J, C_LW, C_SW, C_ILL
  } op_class_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  wait_cnt;
  op_class_t      op_class;
  logic           timeout_hit;

  // Instruction class of the latched opcode.
  always_comb begin
    op_class = C_ILL;
    if      (op_q == OPW'(6'h00)) op_class = C_R;
    else if (op_q == OPW'(6'h06) || op_q == OPW'(6'h07) || op_q == OPW'(6'h08) ||
             op_q == OPW'(6'h09) || op_q == OPW'(6'h0D)) op_class = C_IMM;
    else if (op_q == OPW'(6'h03)) op_class = C_BEQ;
    else if (op_q == OPW'(6'h02)) op_class = C_J;
    else if (op_q == OPW'(6'h23)) op_class = C_LW;
    else if (op_q == OPW'(6'h2B)) op_class = C_SW;
  end

  // This wait cycle would be the TIMEOUT-th without an ack.
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        alu_op   = ADD_ALUOP;             // PC + 4
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = FETCH;
        end
      end
      DECODE: begin
        if (op_class == C_ILL) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_class)
          C_R: begin
            alu_op  = RTYPE_ALUOP;
            state_d = WB;
          end
          C_IMM: begin
            alu_src = 1'b1;
            alu_op  = ALUOPW'(op_q);
            state_d = WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            alu_op  = ADD_ALUOP;          // address calculation
            state_d = MEM;
          end
          C_BEQ: begin
            branch  = 1'b1;
            alu_op  = SUB_ALUOP;
            state_d = FETCH;
          end
          C_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == C_SW);
        if (dmem_ack) begin
          state_d = (op_class == C_SW) ? FETCH : WB;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_class != C_R);
        mem_to_reg = (op_class == C_LW);
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Everything is quiet while reset is held, whatever the old state was.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write) op_q <= opcode;
      // Counter restarts on every state entry, including a FETCH re-entry
      // after a timeout.
      if (state_d != state_q || bus_err)
        wait_cnt <= '0;
      else if (state_q == FETCH || state_q == MEM)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  // Strobe bit positions in the packed observation vector.
  localparam logic [12:0] IREQ = 13'h1000;
  localparam logic [12:0] DREQ = 13'h0800;
  localparam logic [12:0] DWE  = 13'h0400;
  localparam logic [12:0] IRW  = 13'h0200;
  localparam logic [12:0] PCW  = 13'h0100;
  localparam logic [12:0] BR   = 13'h0080;
  localparam logic [12:0] JMP  = 13'h0040;
  localparam logic [12:0] RDST = 13'h0020;
  localparam logic [12:0] ASRC = 13'h0010;
  localparam logic [12:0] M2R  = 13'h0008;
  localparam logic [12:0] RW   = 13'h0004;
  localparam logic [12:0] ILL  = 13'h0002;
  localparam logic [12:0] BERR = 13'h0001;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [5:0] opcode;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, branch, jump;
  logic       reg_dst, alu_src, mem_to_reg, reg_write, illegal, bus_err;
  logic [5:0] alu_op;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .jump(jump),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  // ---- driver: apply inputs mid-cycle, settle, then observe ----
  task automatic step(input logic r, input logic ia, input logic da, input logic [5:0] op);
    @(negedge clk);
    reset    = r;
    imem_ack = ia;
    dmem_ack = da;
    opcode   = op;
    #1;
  endtask

  // ---- checker: {state, alu_op, strobes} against hand-computed values ----
  task automatic chk(input string tag, input logic [2:0] exp_st,
                     input logic [5:0] exp_alu, input logic [12:0] exp_sb);
    logic [21:0] obs, exp;
    obs = {state, alu_op, imem_req, dmem_req, dmem_we, ir_write, pc_write,
           branch, jump, reg_dst, alu_src, mem_to_reg, reg_write, illegal, bus_err};
    exp = {exp_st, exp_alu, exp_sb};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = 6'h00;

    // Reset held two cycles: everything low.
    step(1, 0, 0, 6'h00); chk("rst0", 0, 6'h00, 13'h0);
    step(1, 0, 0, 6'h00); chk("rst1", 0, 6'h00, 13'h0);

    // R-type, zero-wait.
    step(0, 0, 0, 6'h00); chk("r_fetch_wait", 0, 6'h06, IREQ);
    step(0, 1, 0, 6'h00); chk("r_fetch_ack",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("r_decode",     1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("r_exec",       2, 6'h3F, 13'h0);
    step(0, 0, 0, 6'h00); chk("r_wb",         4, 6'h00, RW);

    // LW, dmem_ack on 4th MEM cycle (same cycle the count hits TIMEOUT: ack wins).
    step(0, 1, 0, 6'h23); chk("lw_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("lw_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("lw_exec",   2, 6'h06, ASRC);
    step(0, 0, 0, 6'h00); chk("lw_mem1",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("lw_mem2",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("lw_mem3",   3, 6'h00, DREQ);
    step(0, 0, 1, 6'h00); chk("lw_mem4",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("lw_wb",     4, 6'h00, RW | RDST | M2R);

    // SW; stray dmem_ack during FETCH must be ignored.
    step(0, 0, 1, 6'h00); chk("sw_fetch_stray", 0, 6'h06, IREQ);
    step(0, 1, 0, 6'h2B); chk("sw_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("sw_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("sw_exec",   2, 6'h06, ASRC);
    step(0, 1, 1, 6'h00); chk("sw_mem",    3, 6'h00, DREQ | DWE);
    step(0, 0, 0, 6'h00); chk("sw_done",   0, 6'h06, IREQ);

    // BEQ then J, 3 cycles each.
    step(0, 1, 0, 6'h03); chk("beq_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("beq_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("beq_exec",   2, 6'h08, BR);
    step(0, 1, 0, 6'h02); chk("j_fetch",    0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("j_decode",   1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("j_exec",     2, 6'h00, JMP | PCW);

    // Illegal opcode.
    step(0, 1, 0, 6'h3F); chk("ill_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("ill_decode", 1, 6'h00, ILL);
    step(0, 0, 0, 6'h00); chk("ill_back",   0, 6'h06, IREQ);

    // Immediate (ORI 0x0D); stray acks in DECODE ignored.
    step(0, 1, 0, 6'h0D); chk("imm_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 1, 1, 6'h00); chk("imm_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("imm_exec",   2, 6'h0D, ASRC);
    step(0, 0, 0, 6'h00); chk("imm_wb",     4, 6'h00, RW | RDST);

    // LW with dmem_ack never arriving: bus_err in 4th MEM cycle.
    step(0, 1, 0, 6'h23); chk("to_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("to_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("to_exec",   2, 6'h06, ASRC);
    step(0, 0, 0, 6'h00); chk("to_mem1",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("to_mem2",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("to_mem3",   3, 6'h00, DREQ);
    step(0, 0, 0, 6'h00); chk("to_mem4",   3, 6'h00, DREQ | BERR);

    // Then fetch timeout: imem_ack held low (FETCH cycle 1..4), counter restarts.
    step(0, 0, 0, 6'h00); chk("fto_1", 0, 6'h06, IREQ);
    step(0, 0, 0, 6'h00); chk("fto_2", 0, 6'h06, IREQ);
    step(0, 0, 0, 6'h00); chk("fto_3", 0, 6'h06, IREQ);
    step(0, 0, 0, 6'h00); chk("fto_4", 0, 6'h06, IREQ | BERR);
    step(0, 0, 0, 6'h00); chk("fto_5", 0, 6'h06, IREQ);

    // Reset in the middle of MEM.
    step(0, 1, 0, 6'h23); chk("rm_fetch",  0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("rm_decode", 1, 6'h00, 13'h0);
    step(0, 0, 0, 6'h00); chk("rm_exec",   2, 6'h06, ASRC);
    step(0, 0, 0, 6'h00); chk("rm_mem",    3, 6'h00, DREQ);
    step(1, 0, 1, 6'h00); chk("rm_rst0",   0, 6'h00, 13'h0);
    step(1, 0, 0, 6'h00); chk("rm_rst1",   0, 6'h00, 13'h0);
    step(0, 0, 1, 6'h00); chk("rm_refetch", 0, 6'h06, IREQ);
    // op_q was cleared by reset, so a fresh R-type runs normally.
    step(0, 1, 0, 6'h00); chk("rm_fetch2", 0, 6'h06, IREQ | IRW | PCW);
    step(0, 0, 0, 6'h00); chk("rm_decode2", 1, 6'h00, 13'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
